// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter set-up sequencer: walks a (register, data) table through an I2C
// byte-write master, retries NACKs and reruns the table after a debounced hot-plug interrupt.
module hdmi_cfg_sequencer #(
   parameter int unsigned TBL_LEN   = 31,
   parameter logic [7:0]  DEV_ADDR  = 8'h72,
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned PWR_DLY   = 50000,
   parameter int unsigned INT_DEB   = 50000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iHDMI_INT,
   output logic [7:0]  oTBL_ADDR,
   input  logic [15:0] iTBL_DATA,
   output logic        oI2C_REQ,
   output logic [7:0]  oI2C_DEV,
   output logic [7:0]  oI2C_REG,
   output logic [7:0]  oI2C_DATA,
   input  logic        iI2C_DONE,
   input  logic        iI2C_NACK,
   output logic        oBUSY,
   output logic        oCFG_DONE,
   output logic        oCFG_ERR
);

   // state      | meaning
   // PWR_WAIT   | power-up delay after reset
   // FETCH      | table address presented to the ROM
   // LOAD       | ROM word captured into the write registers
   // REQ        | write requested, waiting for done
   // RETRY      | one idle cycle between a NACK and the re-request
   // NEXT       | advance to the next entry or finish
   // CFG_OK     | whole table written
   // ERR        | an entry ran out of retries
   typedef enum logic [2:0] {
      S_PWR_WAIT = 3'd0,
      S_FETCH    = 3'd1,
      S_LOAD     = 3'd2,
      S_REQ      = 3'd3,
      S_RETRY    = 3'd4,
      S_NEXT     = 3'd5,
      S_CFG_OK   = 3'd6,
      S_ERR      = 3'd7
   } state_t;

   localparam int unsigned PW = (PWR_DLY > 1)   ? $clog2(PWR_DLY)     : 1;
   localparam int unsigned DW = $clog2(INT_DEB + 1);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [PW-1:0] PWR_LAST  = PW'(PWR_DLY - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(INT_DEB - 1);
   localparam logic [DW-1:0] DEB_SAT   = DW'(INT_DEB);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [7:0]    TBL_LAST  = 8'(TBL_LEN - 1);

   state_t        state, state_nxt;
   logic [PW-1:0] pwr_cnt;
   logic [DW-1:0] deb_cnt;
   logic [RW-1:0] retry;
   logic [7:0]    idx;
   logic [7:0]    reg_q, data_q;
   logic          int_s1, int_s2;
   logic          pending;
   logic          int_evt;
   logic          consume;

   // Counter saturates at INT_DEB so a long low period yields a single event.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         int_s1  <= 1'b1;
         int_s2  <= 1'b1;
         deb_cnt <= '0;
      end else begin
         int_s1 <= iHDMI_INT;
         int_s2 <= int_s1;
         if (int_s2)
            deb_cnt <= '0;
         else if (deb_cnt != DEB_SAT)
            deb_cnt <= deb_cnt + DW'(1);
      end
   end

   assign int_evt = !int_s2 && (deb_cnt == DEB_LAST);
   assign consume = pending && ((state == S_CFG_OK) || (state == S_ERR));

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state <= S_PWR_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         pwr_cnt <= '0;
         retry   <= '0;
         idx     <= '0;
         reg_q   <= '0;
         data_q  <= '0;
         pending <= 1'b0;
      end else begin
         if (int_evt)
            pending <= 1'b1;
         else if (consume)
            pending <= 1'b0;

         if ((state == S_PWR_WAIT) && (pwr_cnt != PWR_LAST))
            pwr_cnt <= pwr_cnt + PW'(1);

         case (state)
            S_LOAD: begin
               reg_q  <= iTBL_DATA[15:8];
               data_q <= iTBL_DATA[7:0];
               retry  <= '0;
            end
            S_REQ: begin
               if (iI2C_DONE && iI2C_NACK && (retry != RETRY_MAX))
                  retry <= retry + RW'(1);
            end
            S_NEXT: begin
               if (idx != TBL_LAST)
                  idx <= idx + 8'd1;
            end
            S_CFG_OK, S_ERR: begin
               if (pending)
                  idx <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      oI2C_REQ  = 1'b0;
      oBUSY     = 1'b1;
      oCFG_DONE = 1'b0;
      oCFG_ERR  = 1'b0;
      case (state)
         S_PWR_WAIT: if (pwr_cnt == PWR_LAST) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_LOAD;
         S_LOAD:     state_nxt = S_REQ;
         S_REQ: begin
            oI2C_REQ = 1'b1;
            if (iI2C_DONE) begin
               if (!iI2C_NACK)
                  state_nxt = S_NEXT;
               else if (retry == RETRY_MAX)
                  state_nxt = S_ERR;
               else
                  state_nxt = S_RETRY;
            end
         end
         S_RETRY:    state_nxt = S_REQ;
         S_NEXT:     state_nxt = (idx == TBL_LAST) ? S_CFG_OK : S_FETCH;
         S_CFG_OK: begin
            oBUSY     = 1'b0;
            oCFG_DONE = 1'b1;
            if (pending) state_nxt = S_FETCH;
         end
         S_ERR: begin
            oBUSY    = 1'b0;
            oCFG_ERR = 1'b1;
            if (pending) state_nxt = S_FETCH;
         end
         default:    state_nxt = S_PWR_WAIT;
      endcase
   end

   assign oTBL_ADDR = idx;
   assign oI2C_DEV  = DEV_ADDR;
   assign oI2C_REG  = reg_q;
   assign oI2C_DATA = data_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Bench for hdmi_cfg_sequencer: ROM and I2C master models, an expected-write queue built
// from the table and a NACK plan, and directed scenarios with hand-computed timing.
module tb_hdmi_cfg_sequencer;

   localparam int TBL_LEN    = 4;
   localparam int MAX_RETRY  = 3;
   localparam int PWR_DLY    = 10;
   localparam int INT_DEB    = 8;
   localparam int MASTER_LAT = 5;

   logic        clk;
   logic        rst_n;
   logic        hdmi_int;
   logic [7:0]  tbl_addr;
   logic [15:0] tbl_data;
   logic        req;
   logic [7:0]  i2c_dev, i2c_reg, i2c_data;
   logic        i2c_done, i2c_nack;
   logic        busy, cfg_done, cfg_err;

   logic [15:0] rom [0:TBL_LEN-1] = '{16'h4110, 16'h9837, 16'hAF06, 16'hBA55};
   int          nack_left [0:TBL_LEN-1];
   logic [15:0] exp_q [$];
   int          cmp_cnt   = 0;
   int          fail_cnt  = 0;
   int          req_rises = 0;

   hdmi_cfg_sequencer #(
      .TBL_LEN  (TBL_LEN),
      .DEV_ADDR (8'h72),
      .MAX_RETRY(MAX_RETRY),
      .PWR_DLY  (PWR_DLY),
      .INT_DEB  (INT_DEB)
   ) dut (
      .iCLK     (clk),
      .iRST_N   (rst_n),
      .iHDMI_INT(hdmi_int),
      .oTBL_ADDR(tbl_addr),
      .iTBL_DATA(tbl_data),
      .oI2C_REQ (req),
      .oI2C_DEV (i2c_dev),
      .oI2C_REG (i2c_reg),
      .oI2C_DATA(i2c_data),
      .iI2C_DONE(i2c_done),
      .iI2C_NACK(i2c_nack),
      .oBUSY    (busy),
      .oCFG_DONE(cfg_done),
      .oCFG_ERR (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected writes: each entry is attempted until acked or retries run out.
   task automatic plan_walk(output logic err, output int err_idx);
      err     = 1'b0;
      err_idx = TBL_LEN - 1;
      for (int i = 0; i < TBL_LEN; i++) begin
         int tries;
         tries = (nack_left[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_left[i] + 1;
         for (int t = 0; t < tries; t++) exp_q.push_back(rom[i]);
         if (nack_left[i] > MAX_RETRY) begin
            err     = 1'b1;
            err_idx = i;
            break;
         end
      end
   endtask

   // Table ROM: data for the address of the previous cycle.
   initial begin : rom_model
      logic [7:0] a;
      tbl_data = 16'h0;
      forever begin
         @(negedge clk);
         a = tbl_addr;
         @(posedge clk);
         #1 tbl_data = (int'(a) < TBL_LEN) ? rom[int'(a)] : 16'h0;
      end
   end

   // I2C master: answers each request MASTER_LAT cycles later, NACKing per plan.
   initial begin : master
      logic rst_q;
      bit   active;
      int   lat;
      active   = 0;
      lat      = 0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      forever begin
         @(posedge clk);
         rst_q = rst_n;
         @(negedge clk);
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
         if (!rst_q) begin
            active = 0;
         end else if (active) begin
            if (lat == 0) begin
               i2c_done = 1'b1;
               if (int'(tbl_addr) < TBL_LEN && nack_left[int'(tbl_addr)] > 0) begin
                  i2c_nack = 1'b1;
                  nack_left[int'(tbl_addr)]--;
               end
               active = 0;
            end else begin
               lat--;
            end
         end else if (req) begin
            active = 1;
            lat    = MASTER_LAT - 1;
         end
      end
   end

   // Every-cycle comparison against the expected-write queue.
   initial begin : compare
      logic        rst_q;
      logic        prev_req;
      logic [15:0] prev_wr;
      prev_req = 1'b0;
      prev_wr  = 16'h0;
      forever begin
         @(posedge clk);
         rst_q = rst_n;
         @(negedge clk);
         if (!rst_q) begin
            prev_req = 1'b0;
            continue;
         end
         check("dev_addr", i2c_dev, 8'h72);
         check("status_excl", cfg_done & cfg_err, 0);
         if (req) begin
            check("req_busy", busy, 1);
            check("req_no_status", {cfg_done, cfg_err}, 0);
         end
         if (req && !prev_req) begin
            req_rises++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("write", {i2c_reg, i2c_data}, exp_q.pop_front());
         end else if (req) begin
            check("req_stable", {i2c_reg, i2c_data}, prev_wr);
         end
         prev_req = req;
         prev_wr  = {i2c_reg, i2c_data};
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      hdmi_int = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req", req, 0);
      check("rst_idx", tbl_addr, 0);
      check("rst_reg", i2c_reg, 0);
      check("rst_data", i2c_data, 0);
      check("rst_busy", busy, 1);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      exp_q.delete();
   endtask

   task automatic release_and_time();
      int k;
      rst_n = 1'b1;
      k = 0;
      while (!req && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("first_req_cycle", k, PWR_DLY + 2);
      check("busy_walk", busy, 1);
   endtask

   task automatic wait_status(input int max);
      int k;
      k = 0;
      while (!(cfg_done || cfg_err) && k < max) begin
         @(negedge clk);
         k++;
      end
      check("status_reached", cfg_done | cfg_err, 1);
   endtask

   task automatic check_status(input logic exp_err, input int exp_idx);
      check("cfg_done", cfg_done, !exp_err);
      check("cfg_err", cfg_err, exp_err);
      check("busy_idle", busy, 0);
      check("final_idx", tbl_addr, exp_idx);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic pulse_int(input int n);
      hdmi_int = 1'b0;
      repeat (n) @(negedge clk);
      hdmi_int = 1'b1;
   endtask

   initial begin : scenario
      logic exp_err;
      int   exp_idx;
      int   base;
      int   k;
      int   n;
      rst_n    = 1'b0;
      hdmi_int = 1'b1;
      for (int i = 0; i < TBL_LEN; i++) nack_left[i] = 0;

      // plain walk after power-up
      do_reset();
      base = req_rises;
      plan_walk(exp_err, exp_idx);
      release_and_time();
      wait_status(300);
      check_status(exp_err, exp_idx);
      check("t1_writes", req_rises - base, 4);

      // interrupt one cycle too short
      pulse_int(INT_DEB - 1);
      repeat (30) @(negedge clk);
      check("short_int_done", cfg_done, 1);
      check("short_int_noreq", req_rises - base, 4);

      // long interrupt restarts once; entry 2 NACKed twice on the rerun
      base = req_rises;
      nack_left[2] = 2;
      plan_walk(exp_err, exp_idx);
      hdmi_int = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (j == 10) check("int_before_restart", cfg_done, 1);
         if (j == 11) begin
            check("int_restart", cfg_done, 0);
            check("restart_idx", tbl_addr, 0);
         end
      end
      hdmi_int = 1'b1;
      wait_status(300);
      check_status(exp_err, exp_idx);
      check("retry_writes", req_rises - base, 6);
      repeat (40) @(negedge clk);
      check("single_restart", cfg_done, 1);
      check("single_restart_req", req_rises - base, 6);

      // interrupt mid-walk: flag visible one cycle, then a full rerun
      do_reset();
      plan_walk(exp_err, exp_idx);
      plan_walk(exp_err, exp_idx);
      release_and_time();
      k = 0;
      while (tbl_addr != 8'd2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("reach_entry2", tbl_addr, 2);
      pulse_int(10);
      wait_status(300);
      check("midwalk_done", cfg_done, 1);
      n = 0;
      while (cfg_done && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("done_pulse_len", n, 1);
      wait_status(300);
      check_status(exp_err, exp_idx);

      // entry 1 exhausts its retries
      do_reset();
      nack_left[1] = 4;
      base = req_rises;
      plan_walk(exp_err, exp_idx);
      release_and_time();
      wait_status(300);
      check_status(exp_err, exp_idx);
      check("err_idx_lit", tbl_addr, 1);
      check("nack_writes", req_rises - base, 5);
      repeat (30) @(negedge clk);
      check("err_hold", cfg_err, 1);
      check("no_req_after_err", req_rises - base, 5);

      // restart out of the error state
      plan_walk(exp_err, exp_idx);
      pulse_int(INT_DEB + 4);
      check("err_cleared", cfg_err, 0);
      wait_status(300);
      check_status(exp_err, exp_idx);

      // reset while entry 3 is being requested
      plan_walk(exp_err, exp_idx);
      pulse_int(INT_DEB + 4);
      k = 0;
      while (!(req && tbl_addr == 8'd3) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("reach_entry3_req", {req, tbl_addr}, {1'b1, 8'd3});
      rst_n = 1'b0;
      @(negedge clk);
      check("midreq_rst_req", req, 0);
      check("midreq_rst_idx", tbl_addr, 0);
      check("midreq_rst_busy", busy, 1);
      check("midreq_rst_reg", {i2c_reg, i2c_data}, 0);
      do_reset();
      plan_walk(exp_err, exp_idx);
      release_and_time();
      wait_status(300);
      check_status(exp_err, exp_idx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

endmodule
